// File: rtl/base_shift_pipe.sv
// Pipelined multi-mode barrel shifter (lsr/asr/ror/lsl) with valid/ready flow control.
// Port vectors are MSB-at-index-0; internally everything is handled by value.
module base_shift_pipe #(
    parameter int width  = 1,
    parameter int swidth = (width == 1) ? 1 : $clog2(width),
    parameter int stages = 1,
    parameter int twidth = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_v,
    output logic              i_r,
    input  logic [0:1]        i_mode,
    input  logic [0:swidth-1] i_samt,
    input  logic [0:width-1]  i_d,
    input  logic [0:twidth-1] i_tag,
    output logic              o_v,
    input  logic              o_r,
    output logic [0:width-1]  o_d,
    output logic [0:twidth-1] o_tag
);

    localparam logic [1:0] mode_lsr = 2'b00;
    localparam logic [1:0] mode_asr = 2'b01;
    localparam logic [1:0] mode_ror = 2'b10;
    localparam int base_n = swidth / stages;
    localparam int rem_n  = swidth % stages;

    logic [stages-1:0] v;
    logic [stages-1:0] v_in;
    logic [stages:0]   rdy;

    // One binary sub-shift by a positions; a is always a power of two below width
    // (or 1 when width==1), so rotation only needs a mod width.
    function automatic logic [width-1:0] sub_shift(input logic [width-1:0] x,
                                                   input logic [1:0] m,
                                                   input logic sg,
                                                   input int a);
        logic [2*width-1:0] dbl;
        logic [width-1:0]   fill;
        int                 ar;
        ar   = a % width;
        dbl  = {x, x} >> ar;
        fill = ~({width{1'b1}} >> a);
        case (m)
            mode_lsr: sub_shift = x >> a;
            mode_asr: sub_shift = (x >> a) | (fill & {width{sg}});
            mode_ror: sub_shift = dbl[width-1:0];
            default:  sub_shift = x << a;
        endcase
    endfunction

    always_comb begin
        rdy = '0;
        rdy[stages] = o_r;
        for (int k = stages - 1; k >= 0; k--) begin
            rdy[k] = ~v[k] | rdy[k+1];
        end
    end

    always_comb begin
        v_in    = '0;
        v_in[0] = i_v;
        for (int k = 1; k < stages; k++) begin
            v_in[k] = v[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
        end else begin
            for (int k = 0; k < stages; k++) begin
                if (rdy[k]) v[k] <= v_in[k];
            end
        end
    end

    for (genvar k = 0; k < stages; k++) begin : g_stage
        // Earlier stages take one extra sub-shift when swidth does not divide evenly.
        localparam int n_k = base_n + ((k < rem_n) ? 1 : 0);
        localparam int j0  = k * base_n + ((k < rem_n) ? k : rem_n);

        logic [width-1:0]  d_in, x, d_q;
        logic [1:0]        m_in, m_q;
        logic [swidth-1:0] s_in, s_q;
        logic              sg_in, sg_q;
        logic [twidth-1:0] t_in, t_q;

        if (k == 0) begin : g_src
            assign d_in  = i_d;
            assign m_in  = i_mode;
            assign s_in  = i_samt;
            assign sg_in = i_d[0];
            assign t_in  = i_tag;
        end else begin : g_src
            assign d_in  = g_stage[k-1].d_q;
            assign m_in  = g_stage[k-1].m_q;
            assign s_in  = g_stage[k-1].s_q;
            assign sg_in = g_stage[k-1].sg_q;
            assign t_in  = g_stage[k-1].t_q;
        end

        always_comb begin
            x = d_in;
            for (int j = j0; j < j0 + n_k; j++) begin
                if (s_in[j]) x = sub_shift(x, m_in, sg_in, 1 << j);
            end
        end

        always_ff @(posedge clk) begin
            if (rdy[k]) begin
                d_q  <= x;
                m_q  <= m_in;
                s_q  <= s_in;
                sg_q <= sg_in;
                t_q  <= t_in;
            end
        end
    end

    assign i_r   = rdy[0];
    assign o_v   = v[stages-1];
    assign o_d   = g_stage[stages-1].d_q;
    assign o_tag = g_stage[stages-1].t_q;

endmodule

// File: tb/tb_base_shift_pipe.sv
// Directed bench for base_shift_pipe: four configurations with hand-computed results.
module tb_base_shift_pipe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // a: width 8, 1 stage
    logic       a_iv = 0, a_ir, a_ov, a_or = 1;
    logic [1:0] a_mode = 0;
    logic [2:0] a_samt = 0;
    logic [7:0] a_d = 0, a_od;
    logic [3:0] a_tag = 0, a_otag;
    // b: width 8, 3 stages
    logic       b_iv = 0, b_ir, b_ov, b_or = 1;
    logic [1:0] b_mode = 0;
    logic [2:0] b_samt = 0;
    logic [7:0] b_d = 0, b_od;
    logic [3:0] b_tag = 0, b_otag;
    // c: width 6, 2 stages
    logic       c_iv = 0, c_ir, c_ov, c_or = 1;
    logic [1:0] c_mode = 0;
    logic [2:0] c_samt = 0;
    logic [5:0] c_d = 0, c_od;
    logic [3:0] c_tag = 0, c_otag;
    // e: width 1, 1 stage
    logic       e_iv = 0, e_ir, e_ov, e_or = 1;
    logic [1:0] e_mode = 0;
    logic [0:0] e_samt = 0;
    logic [0:0] e_d = 0, e_od;
    logic [3:0] e_tag = 0, e_otag;

    base_shift_pipe #(.width(8), .stages(1), .twidth(4)) u_a (
        .clk(clk), .reset(reset), .i_v(a_iv), .i_r(a_ir), .i_mode(a_mode), .i_samt(a_samt),
        .i_d(a_d), .i_tag(a_tag), .o_v(a_ov), .o_r(a_or), .o_d(a_od), .o_tag(a_otag));
    base_shift_pipe #(.width(8), .stages(3), .twidth(4)) u_b (
        .clk(clk), .reset(reset), .i_v(b_iv), .i_r(b_ir), .i_mode(b_mode), .i_samt(b_samt),
        .i_d(b_d), .i_tag(b_tag), .o_v(b_ov), .o_r(b_or), .o_d(b_od), .o_tag(b_otag));
    base_shift_pipe #(.width(6), .stages(2), .twidth(4)) u_c (
        .clk(clk), .reset(reset), .i_v(c_iv), .i_r(c_ir), .i_mode(c_mode), .i_samt(c_samt),
        .i_d(c_d), .i_tag(c_tag), .o_v(c_ov), .o_r(c_or), .o_d(c_od), .o_tag(c_otag));
    base_shift_pipe #(.width(1), .stages(1), .twidth(4)) u_e (
        .clk(clk), .reset(reset), .i_v(e_iv), .i_r(e_ir), .i_mode(e_mode), .i_samt(e_samt),
        .i_d(e_d), .i_tag(e_tag), .o_v(e_ov), .o_r(e_or), .o_d(e_od), .o_tag(e_otag));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic op_a(input logic [1:0] m, input logic [2:0] s, input logic [7:0] d,
                        input logic [7:0] exp, input string nm);
        @(negedge clk);
        chk({nm, "_idle"}, a_ov, 1'b0);
        a_iv = 1; a_mode = m; a_samt = s; a_d = d; a_tag = {1'b0, s};
        chk({nm, "_ir"}, a_ir, 1'b1);
        @(negedge clk);
        a_iv = 0;
        chk({nm, "_ov"}, a_ov, 1'b1);
        chk({nm, "_d"}, a_od, exp);
        chk({nm, "_tag"}, a_otag, {1'b0, s});
    endtask

    task automatic op_c(input logic [1:0] m, input logic [2:0] s, input logic [5:0] d,
                        input logic [5:0] exp, input string nm);
        @(negedge clk);
        c_iv = 1; c_mode = m; c_samt = s; c_d = d; c_tag = {1'b1, s};
        @(negedge clk);
        c_iv = 0;
        chk({nm, "_early"}, c_ov, 1'b0);
        @(negedge clk);
        chk({nm, "_ov"}, c_ov, 1'b1);
        chk({nm, "_d"}, c_od, exp);
        chk({nm, "_tag"}, c_otag, {1'b1, s});
        @(negedge clk);
        chk({nm, "_after"}, c_ov, 1'b0);
    endtask

    task automatic op_e(input logic [1:0] m, input logic s, input logic d,
                        input logic exp, input string nm);
        @(negedge clk);
        e_iv = 1; e_mode = m; e_samt = s; e_d = d; e_tag = {3'b0, s};
        @(negedge clk);
        e_iv = 0;
        chk({nm, "_ov"}, e_ov, 1'b1);
        chk({nm, "_d"}, e_od, exp);
        @(negedge clk);
        chk({nm, "_after"}, e_ov, 1'b0);
    endtask

    logic [1:0] b_m [8]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [2:0] b_s [8]  = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd7, 3'd7, 3'd4, 3'd5};
    logic [7:0] b_x [8]  = '{8'h4B, 8'hCB, 8'h4B, 8'h2C, 8'h01, 8'hFF, 8'h69, 8'hC0};
    logic [7:0] b3_x [4] = '{8'h96, 8'h4B, 8'hA5, 8'hD2};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_a_ov", a_ov, 1'b0);
        chk("rst_b_ov", b_ov, 1'b0);
        chk("rst_b_ir", b_ir, 1'b1);
        chk("rst_c_ov", c_ov, 1'b0);
        chk("rst_e_ov", e_ov, 1'b0);
        reset = 0;

        // width 8, 1 stage: the four modes at samt=3, then samt=0 and edge cases
        op_a(2'd0, 3'd3, 8'h96, 8'h12, "a_lsr3");
        op_a(2'd1, 3'd3, 8'h96, 8'hF2, "a_asr3");
        op_a(2'd2, 3'd3, 8'h96, 8'hD2, "a_ror3");
        op_a(2'd3, 3'd3, 8'h96, 8'hB0, "a_lsl3");
        op_a(2'd0, 3'd0, 8'h96, 8'h96, "a_lsr0");
        op_a(2'd1, 3'd0, 8'h96, 8'h96, "a_asr0");
        op_a(2'd2, 3'd0, 8'h96, 8'h96, "a_ror0");
        op_a(2'd3, 3'd0, 8'h96, 8'h96, "a_lsl0");
        op_a(2'd2, 3'd1, 8'h01, 8'h80, "a_ror_wrap");
        op_a(2'd3, 3'd7, 8'h5B, 8'h80, "a_lsl7");
        op_a(2'd1, 3'd7, 8'h5A, 8'h00, "a_asr7_pos");

        // width 6: samt beyond width, uneven stage split
        op_c(2'd0, 3'd7, 6'b100101, 6'b000000, "c_lsr7");
        op_c(2'd3, 3'd7, 6'b100101, 6'b000000, "c_lsl7");
        op_c(2'd1, 3'd7, 6'b100101, 6'b111111, "c_asr7");
        op_c(2'd2, 3'd7, 6'b100101, 6'b110010, "c_ror7");
        op_c(2'd2, 3'd6, 6'b100101, 6'b100101, "c_ror6");
        op_c(2'd2, 3'd2, 6'b100101, 6'b011001, "c_ror2");
        op_c(2'd0, 3'd1, 6'b100101, 6'b010010, "c_lsr1");
        op_c(2'd1, 3'd1, 6'b100101, 6'b110010, "c_asr1");

        // width 1
        op_e(2'd0, 1'b1, 1'b1, 1'b0, "e_lsr1");
        op_e(2'd1, 1'b1, 1'b1, 1'b1, "e_asr1");
        op_e(2'd2, 1'b1, 1'b1, 1'b1, "e_ror1");
        op_e(2'd3, 1'b1, 1'b1, 1'b0, "e_lsl1");
        op_e(2'd0, 1'b0, 1'b1, 1'b1, "e_lsr0");

        // 3 stages, back-to-back with o_r high
        b_or = 1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n >= 3 && n < 11) begin
                chk("b2_ov", b_ov, 1'b1);
                chk("b2_d", b_od, b_x[n-3]);
                chk("b2_tag", b_otag, n - 3);
            end else begin
                chk("b2_ov_idle", b_ov, 1'b0);
            end
            if (n < 8) begin
                b_iv = 1; b_mode = b_m[n]; b_samt = b_s[n]; b_d = 8'h96; b_tag = n[3:0];
                chk("b2_ir", b_ir, 1'b1);
            end else begin
                b_iv = 0;
            end
        end

        // 3 stages, output stall with a full pipe
        b_or = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            b_iv = 1; b_mode = 2'd2; b_d = 8'h96;
            if (n < 3) begin
                b_samt = n[2:0]; b_tag = 4'd8 + n[3:0];
                chk("b3_ir_fill", b_ir, 1'b1);
                chk("b3_ov_fill", b_ov, 1'b0);
            end else begin
                b_samt = 3'd3; b_tag = 4'd11;
                chk("b3_ir_stall", b_ir, 1'b0);
                chk("b3_ov_stall", b_ov, 1'b1);
                chk("b3_tag_stall", b_otag, 4'd8);
                chk("b3_d_stall", b_od, 8'h96);
            end
        end
        @(negedge clk);
        b_or = 1;
        #1;
        chk("b3_ir_release", b_ir, 1'b1);
        chk("b3_tag_release", b_otag, 4'd8);
        for (int n = 9; n < 13; n++) begin
            @(negedge clk);
            b_iv = 0;
            if (n < 12) begin
                chk("b3_ov_drain", b_ov, 1'b1);
                chk("b3_tag_drain", b_otag, n);
                chk("b3_d_drain", b_od, b3_x[n-8]);
            end else begin
                chk("b3_ov_empty", b_ov, 1'b0);
            end
        end

        // reset with two operations in flight
        @(negedge clk);
        b_iv = 1; b_mode = 2'd0; b_samt = 3'd0; b_d = 8'h11; b_tag = 4'd1;
        @(negedge clk);
        b_tag = 4'd2;
        @(negedge clk);
        b_iv = 0; b_or = 0; reset = 1;
        @(negedge clk);
        chk("b6_ov_rst", b_ov, 1'b0);
        chk("b6_ir_rst", b_ir, 1'b1);
        reset = 0; b_or = 1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("b6_no_stale", b_ov, 1'b0);
        end
        b_iv = 1; b_mode = 2'd3; b_samt = 3'd3; b_d = 8'h96; b_tag = 4'd6;
        @(negedge clk);
        b_iv = 0;
        @(negedge clk);
        chk("b6_new_early", b_ov, 1'b0);
        @(negedge clk);
        chk("b6_new_ov", b_ov, 1'b1);
        chk("b6_new_d", b_od, 8'hB0);
        chk("b6_new_tag", b_otag, 4'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
